// File: rtl/spi_pkg.sv
// +----------------------------------------------------------------------------+
// | spi_pkg                                                                    |
// | Shared state encoding, frame constants and edge helpers for spi_tx_master. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } spi_state_e;

  localparam int SPI_BITS   = 8;
  localparam int SPI_EDGE_W = 5;
  localparam logic [SPI_EDGE_W-1:0] SPI_EDGES = 5'd16;

  // Edge numbers run 1..16; odd numbers are leading edges.
  // With CPHA=1 bit7 is already on MOSI before edge 1, so the first leading edge must not shift.
  function automatic logic spi_shift_edge(input logic cpha, input logic [SPI_EDGE_W-1:0] edge_num);
    if (cpha) begin
      return edge_num[0] && (edge_num != SPI_EDGE_W'(1));
    end
    return !edge_num[0] && (edge_num != SPI_EDGES);
  endfunction

  function automatic logic spi_sample_edge(input logic cpha, input logic [SPI_EDGE_W-1:0] edge_num);
    return cpha ? !edge_num[0] : edge_num[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tx_master_if.sv
// +----------------------------------------------------------------------------+
// | spi_tx_master_if                                                           |
// | Byte stream, SPI pins and receive stream of the SPI transmit master.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface spi_tx_master_if;
  import spi_pkg::*;

  logic [SPI_BITS-1:0] data_i;
  logic                last_i;
  logic                valid_i;
  logic                ready_o;
  logic                sck_o;
  logic                ssel_o;
  logic                mosi_o;
  logic                miso_i;
  logic [SPI_BITS-1:0] rx_data_or;
  logic                rx_valid_o;
  logic                busy_o;

  // master: the SPI master block itself; slave: its producer/environment side.
  modport master (
    input  data_i, last_i, valid_i, miso_i,
    output ready_o, sck_o, ssel_o, mosi_o, rx_data_or, rx_valid_o, busy_o
  );

  modport slave (
    output data_i, last_i, valid_i, miso_i,
    input  ready_o, sck_o, ssel_o, mosi_o, rx_data_or, rx_valid_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/spi_clk_div.sv
// +----------------------------------------------------------------------------+
// | spi_clk_div                                                                |
// | Half-period counter producing a one-cycle tick every CLK_DIV cycles.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [7:0] c_DIV_MAX = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  assign tick_o = en_i && (r_cnt == c_DIV_MAX);

  // Held at zero while disabled so every enabled state starts a full half-period.
  always_ff @(posedge clk_i) begin
    if (reset_i || !en_i || clr_i) begin
      r_cnt <= '0;
    end else if (tick_o) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_tx_master.sv
// +----------------------------------------------------------------------------+
// | spi_tx_master                                                              |
// | SPI master serialising a valid/ready byte stream onto SCK/MOSI/SSEL.       |
// | Optional MISO capture: define SPI_TX_MISO_CAPTURE_EN.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_tx_master
  import spi_pkg::*;
#(
  parameter logic CPOL     = 1'b0,
  parameter logic CPHA     = 1'b0,
  parameter int   CLK_DIV  = 4,
  parameter int   SSEL_GAP = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  spi_tx_master_if.master bus
);

  localparam int c_GAP_W = (SSEL_GAP > 1) ? $clog2(SSEL_GAP) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(SSEL_GAP - 1);

  spi_state_e r_state;
  spi_state_e w_state_next;

  logic                  w_tick;
  logic                  w_div_en;
  logic                  w_div_clr;
  logic                  w_ready;
  logic                  w_xfer;
  logic                  w_edge_issue;
  logic                  w_last_edge;
  logic                  w_gap_done;
  logic [SPI_EDGE_W-1:0] w_edge_num;

  logic [SPI_BITS-1:0]   r_tx_sr;
  logic                  r_last;
  logic                  r_sck;
  logic [SPI_EDGE_W-1:0] r_edge_cnt;
  logic [c_GAP_W-1:0]    r_gap_cnt;

  assign w_div_en     = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
  assign w_div_clr    = (w_state_next != r_state);
  assign w_edge_issue = w_tick && ((r_state == SETUP) || (r_state == SHIFT));
  assign w_edge_num   = r_edge_cnt + SPI_EDGE_W'(1);
  assign w_last_edge  = w_edge_issue && (w_edge_num == SPI_EDGES);
  assign w_gap_done   = (r_state == GAP) && (r_gap_cnt == c_GAP_MAX);
  assign w_xfer       = bus.valid_i && w_ready;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (w_div_en),
    .clr_i   (w_div_clr),
    .tick_o  (w_tick)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.valid_i) w_state_next = SETUP;
      end
      SETUP: begin
        if (w_tick) w_state_next = SHIFT;
      end
      SHIFT: begin
        if (w_last_edge) begin
          if (r_last) begin
            w_state_next = HOLD;
          end else begin
            // Accepting here chains the next byte with no SCK gap.
            w_ready      = 1'b1;
            w_state_next = bus.valid_i ? SHIFT : WAIT;
          end
        end
      end
      WAIT: begin
        w_ready = 1'b1;
        if (bus.valid_i) w_state_next = SHIFT;
      end
      HOLD: begin
        if (w_tick) w_state_next = GAP;
      end
      GAP: begin
        if (w_gap_done) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (reset_i) w_ready = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sck      <= CPOL;
      r_tx_sr    <= '0;
      r_last     <= 1'b0;
      r_edge_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (w_xfer) begin
        r_tx_sr <= bus.data_i;
        r_last  <= bus.last_i;
      end else if (w_edge_issue && spi_shift_edge(CPHA, w_edge_num)) begin
        r_tx_sr <= {r_tx_sr[SPI_BITS-2:0], 1'b0};
      end
      if (w_edge_issue) begin
        r_sck      <= ~r_sck;
        r_edge_cnt <= w_last_edge ? '0 : w_edge_num;
      end
      if (r_state == GAP) begin
        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.sck_o   = r_sck;
  assign bus.ssel_o  = (r_state == IDLE) || (r_state == GAP);
  assign bus.mosi_o  = r_tx_sr[SPI_BITS-1];
  assign bus.busy_o  = (r_state != IDLE);

`ifdef SPI_TX_MISO_CAPTURE_EN
  logic [SPI_BITS-1:0] r_rx_sr;
  logic [SPI_BITS-1:0] r_rx_data;
  logic                r_rx_pend;
  logic                r_rx_valid;

  // The strobe trails edge 16 by one cycle so both CPHA modes report at the same time.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_rx_pend  <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_edge_issue && spi_sample_edge(CPHA, w_edge_num)) begin
        r_rx_sr <= {r_rx_sr[SPI_BITS-2:0], bus.miso_i};
      end
      r_rx_pend  <= w_last_edge;
      r_rx_valid <= r_rx_pend;
      if (r_rx_pend) r_rx_data <= r_rx_sr;
    end
  end

  assign bus.rx_data_or = r_rx_data;
  assign bus.rx_valid_o = r_rx_valid;
`else
  logic w_unused_miso;
  assign w_unused_miso  = bus.miso_i;
  assign bus.rx_data_or = '0;
  assign bus.rx_valid_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_tx_master.sv
// +----------------------------------------------------------------------------+
// | tb_spi_tx_master                                                           |
// | Directed bench for spi_tx_master (CPOL/CPHA 0/0 and 1/1, CLK_DIV=4).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spi_tx_master;

  localparam int NCAP = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_tx_master_if if0 ();
  spi_tx_master_if if1 ();

  spi_tx_master #(.CPOL(1'b0), .CPHA(1'b0), .CLK_DIV(4), .SSEL_GAP(2)) u_dut0 (
    .clk_i(clk), .reset_i(rst), .bus(if0.master)
  );
  spi_tx_master #(.CPOL(1'b1), .CPHA(1'b1), .CLK_DIV(4), .SSEL_GAP(2)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .bus(if1.master)
  );

  // dut0 loops MOSI back; dut1 sees MISO tied high.
  assign if0.miso_i = if0.mosi_o;
  assign if1.miso_i = 1'b1;

  int n_checks;
  int n_err;
  int sel;

  logic       cap_sck  [NCAP];
  logic       cap_ssel [NCAP];
  logic       cap_mosi [NCAP];
  logic       cap_rdy  [NCAP];
  logic       cap_rxv  [NCAP];
  logic       cap_busy [NCAP];
  logic [7:0] cap_rxd  [NCAP];

  int         ev_c [8];
  logic       ev_v [8];
  logic [7:0] ev_d [8];
  logic       ev_l [8];
  logic       ev_r [8];
  int         nev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_ev(input int c, input logic v, input logic [7:0] d, input logic l, input logic r);
    ev_c[nev] = c; ev_v[nev] = v; ev_d[nev] = d; ev_l[nev] = l; ev_r[nev] = r;
    nev++;
  endtask

  task automatic sample(input int c);
    if (sel == 0) begin
      cap_sck[c] = if0.sck_o; cap_ssel[c] = if0.ssel_o; cap_mosi[c] = if0.mosi_o;
      cap_rdy[c] = if0.ready_o; cap_rxv[c] = if0.rx_valid_o; cap_busy[c] = if0.busy_o;
      cap_rxd[c] = if0.rx_data_or;
    end else begin
      cap_sck[c] = if1.sck_o; cap_ssel[c] = if1.ssel_o; cap_mosi[c] = if1.mosi_o;
      cap_rdy[c] = if1.ready_o; cap_rxv[c] = if1.rx_valid_o; cap_busy[c] = if1.busy_o;
      cap_rxd[c] = if1.rx_data_or;
    end
  endtask

  // Cycle 0 is the cycle in which the first event (normally the transfer) is driven.
  task automatic run(input int n);
    for (int c = 0; c <= n; c++) begin
      if (c > 0) @(negedge clk);
      sample(c);
      for (int i = 0; i < nev; i++) begin
        if (ev_c[i] == c) begin
          rst = ev_r[i];
          if (sel == 0) begin
            if0.valid_i = ev_v[i]; if0.data_i = ev_d[i]; if0.last_i = ev_l[i];
          end else begin
            if1.valid_i = ev_v[i]; if1.data_i = ev_d[i]; if1.last_i = ev_l[i];
          end
        end
      end
    end
    nev = 0;
  endtask

  function automatic int n_tog(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (cap_sck[c] !== cap_sck[c-1]) n++;
    return n;
  endfunction

  // Toggles outside the expected grid (every 4 cycles from cycle 5 up to 'last').
  function automatic int n_tog_off(input int b, input int last);
    int n = 0;
    for (int c = 1; c <= b; c++)
      if ((cap_sck[c] !== cap_sck[c-1]) && (((c - 1) % 4 != 0) || c < 5 || c > last)) n++;
    return n;
  endfunction

  function automatic int n_rxv(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (cap_rxv[c] === 1'b1) n++;
    return n;
  endfunction

  function automatic int n_ssel_low(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (cap_ssel[c] === 1'b0) n++;
    return n;
  endfunction

  initial begin
    logic [7:0]  b;
    logic [23:0] seq;
    int          n;

    n_checks = 0; n_err = 0; sel = 0; nev = 0; rst = 1'b1;
    if0.valid_i = 1'b0; if0.data_i = '0; if0.last_i = 1'b0;
    if1.valid_i = 1'b0; if1.data_i = '0; if1.last_i = 1'b0;

    // Reset values while asserted.
    repeat (2) @(negedge clk);
    chk("rst_sck0",   if0.sck_o,      32'd0);
    chk("rst_sck1",   if1.sck_o,      32'd1);
    chk("rst_ssel",   {if0.ssel_o, if1.ssel_o}, 32'd3);
    chk("rst_mosi",   {if0.mosi_o, if1.mosi_o}, 32'd0);
    chk("rst_ready",  {if0.ready_o, if1.ready_o}, 32'd0);
    chk("rst_busy",   {if0.busy_o, if1.busy_o}, 32'd0);
    chk("rst_rx",     {if0.rx_data_or, if0.rx_valid_o, if1.rx_data_or, if1.rx_valid_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready",  {if0.ready_o, if1.ready_o}, 32'd3);
    chk("rel_idle",   {if0.ssel_o, if0.sck_o, if1.ssel_o, if1.sck_o}, 32'b1011);

    // Single byte 0xA5, CPOL=0 CPHA=0, MOSI looped back.
    sel = 0;
    add_ev(0, 1'b1, 8'hA5, 1'b1, 1'b0);
    add_ev(1, 1'b0, 8'h00, 1'b0, 1'b0);
    run(80);
    chk("s1_ssel_mosi_t1", {cap_ssel[1], cap_mosi[1]}, 32'b01);
    chk("s1_ssel_low",     n_ssel_low(0, 80), 32'd68);
    chk("s1_ssel_rise",    {cap_ssel[68], cap_ssel[69]}, 32'b01);
    chk("s1_edges",        n_tog(1, 80), 32'd16);
    chk("s1_edge_grid",    n_tog_off(80, 65), 32'd0);
    b = '0; n = 0;
    for (int k = 1; k <= 15; k += 2) begin
      b = {b[6:0], cap_mosi[1+4*k]};
      if (cap_mosi[1+4*k] !== cap_mosi[4*k] || cap_sck[1+4*k] !== 1'b1) n++;
    end
    chk("s1_mosi_bits",    b, 32'hA5);
    chk("s1_mosi_stable",  n, 32'd0);
    chk("s1_ready_back",   {cap_rdy[70], cap_rdy[71], cap_busy[70], cap_busy[71]}, 32'b0110);
`ifdef SPI_TX_MISO_CAPTURE_EN
    chk("s1_rxv_count",    n_rxv(0, 80), 32'd1);
    chk("s1_rx_data",      {cap_rxv[66], cap_rxd[66]}, {23'd0, 1'b1, 8'hA5});
`else
    chk("s1_rxv_none",     n_rxv(0, 80), 32'd0);
    chk("s1_rxd_zero",     cap_rxd[80], 32'd0);
`endif

    // Single byte 0x3C, CPOL=1 CPHA=1, MISO tied high.
    sel = 1;
    add_ev(0, 1'b1, 8'h3C, 1'b1, 1'b0);
    add_ev(1, 1'b0, 8'h00, 1'b0, 1'b0);
    run(80);
    chk("s2_sck_idle",     {cap_sck[0], cap_sck[80]}, 32'b11);
    chk("s2_edges",        n_tog(1, 80), 32'd16);
    chk("s2_edge1_fall",   {cap_sck[4], cap_sck[5]}, 32'b10);
    b = '0; n = 0;
    for (int k = 2; k <= 16; k += 2) b = {b[6:0], cap_mosi[1+4*k]};
    for (int c = 2; c <= 80; c++)
      if (cap_mosi[c] !== cap_mosi[c-1] && !(cap_sck[c-1] === 1'b1 && cap_sck[c] === 1'b0)) n++;
    chk("s2_mosi_bits",    b, 32'h3C);
    chk("s2_mosi_on_fall", n, 32'd0);
`ifdef SPI_TX_MISO_CAPTURE_EN
    chk("s2_rx_data",      {cap_rxv[66], cap_rxd[66]}, {23'd0, 1'b1, 8'hFF});
`else
    chk("s2_rxv_none",     n_rxv(0, 80), 32'd0);
`endif

    // Three-byte frame with valid held high: continuous SCK.
    sel = 0;
    add_ev(0,   1'b1, 8'h01, 1'b0, 1'b0);
    add_ev(1,   1'b1, 8'h02, 1'b0, 1'b0);
    add_ev(65,  1'b1, 8'h03, 1'b1, 1'b0);
    add_ev(129, 1'b0, 8'h00, 1'b0, 1'b0);
    run(210);
    chk("s3_edges",        n_tog(1, 210), 32'd48);
    chk("s3_edge_grid",    n_tog_off(210, 193), 32'd0);
    chk("s3_ssel_low",     n_ssel_low(1, 196), 32'd196);
    chk("s3_ssel_rise",    cap_ssel[197], 32'd1);
`ifdef SPI_TX_MISO_CAPTURE_EN
    seq = {cap_rxd[66], cap_rxd[130], cap_rxd[194]};
    chk("s3_rxv_count",    n_rxv(0, 210), 32'd3);
    chk("s3_rxv_pos",      {cap_rxv[66], cap_rxv[130], cap_rxv[194]}, 32'b111);
    chk("s3_rx_seq",       seq, 32'h010203);
`else
    chk("s3_rxv_none",     n_rxv(0, 210), 32'd0);
`endif

    // valid withheld 20 cycles between two bytes of one frame.
    add_ev(0,  1'b1, 8'h55, 1'b0, 1'b0);
    add_ev(1,  1'b0, 8'h00, 1'b0, 1'b0);
    add_ev(85, 1'b1, 8'h69, 1'b1, 1'b0);
    add_ev(86, 1'b0, 8'h00, 1'b0, 1'b0);
    run(170);
    n = 0;
    for (int c = 65; c <= 85; c++) if (cap_sck[c] !== 1'b0 || cap_ssel[c] !== 1'b0) n++;
    chk("s4_wait_idle",    n, 32'd0);
    chk("s4_wait_ready",   cap_rdy[75], 32'd1);
    chk("s4_no_edges",     n_tog(66, 89), 32'd0);
    chk("s4_edge1",        {cap_sck[89], cap_sck[90]}, 32'b01);
    chk("s4_mosi_load",    {cap_mosi[85], cap_mosi[86]}, 32'b10);
    chk("s4_ssel_rise",    {cap_ssel[153], cap_ssel[154]}, 32'b01);
`ifdef SPI_TX_MISO_CAPTURE_EN
    chk("s4_rxv_count",    n_rxv(0, 170), 32'd2);
    chk("s4_rx_data",      {cap_rxv[151], cap_rxd[151]}, {23'd0, 1'b1, 8'h69});
`else
    chk("s4_rxv_none",     n_rxv(0, 170), 32'd0);
`endif

    // Reset asserted in the cycle edge 7 appears.
    add_ev(0,  1'b1, 8'hC3, 1'b1, 1'b0);
    add_ev(1,  1'b0, 8'h00, 1'b0, 1'b0);
    add_ev(29, 1'b0, 8'h00, 1'b0, 1'b1);
    add_ev(31, 1'b0, 8'h00, 1'b0, 1'b0);
    run(100);
    chk("s5_edge7",        {cap_sck[28], cap_sck[29]}, 32'b01);
    chk("s5_abort",        {cap_ssel[30], cap_sck[30], cap_busy[30], cap_mosi[30]}, 32'b1000);
    chk("s5_ready_rel",    {cap_rdy[31], cap_rdy[32]}, 32'b01);
    chk("s5_ssel_high",    n_ssel_low(30, 100), 32'd0);
    chk("s5_no_rxv",       n_rxv(0, 100), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_tx_master.md
# spi_tx_master

SPI master that serialises bytes from an on-chip valid/ready stream onto SCK/MOSI/SSEL. It optionally captures MISO into a received-byte stream. It is the initiator for the FPGA's SPI receiver blocks and for board-level SPI peripherals. Frames are delimited by the producer's `last_i` flag; SSEL is held low across all bytes of a frame.

## Interface
- `CPOL`, 1'b0, SCK idle level.
- `CPHA`, 1'b0, 0: sample on leading edge, shift on trailing edge; 1: shift on leading edge, sample on trailing edge.
- `CLK_DIV`, 4, SCK half-period in `clk_i` cycles; legal range 2..255.
- `SSEL_GAP`, 2, minimum `clk_i` cycles SSEL stays high between frames; legal range ≥1.
- `clk_i`  in  1  system clock; the only clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `data_i`  in  8  byte to transmit, MSB first.
- `last_i`  in  1  qualifies `data_i`; 1 means this byte ends the frame.
- `valid_i`  in  1  `data_i`/`last_i` valid.
- `ready_o`  out  1  block can accept a byte this cycle.
- `sck_o`  out  1  SPI clock.
- `ssel_o`  out  1  slave select, active low.
- `mosi_o`  out  1  serial data out.
- `miso_i`  in  1  serial data in; externally synchronised.
- `rx_data_or`  out  8  last received byte.
- `rx_valid_o`  out  1  one-cycle strobe, `rx_data_or` updated.
- `busy_o`  out  1  high from acceptance of a frame's first byte until return to IDLE.

## Operation
- Handshake: a byte transfers when `valid_i && ready_o` are both high in the same cycle. `data_i` and `last_i` are registered on transfer.
- States:
  - IDLE: `ready_o`=1, `ssel_o`=1. On transfer → SETUP.
  - SETUP: `ssel_o`=0, `mosi_o`=bit7. Lasts CLK_DIV cycles → SHIFT.
  - SHIFT: 16 SCK edges, CLK_DIV cycles apart; bit counter 0..7. Exit after edge 16 → WAIT if `last`=0, → HOLD if `last`=1.
  - WAIT: `ssel_o`=0, `sck_o`=CPOL, `ready_o`=1. On transfer, load byte; `mosi_o`=bit7 next cycle; edge 1 follows CLK_DIV cycles later in SHIFT.
  - HOLD: `ssel_o`=0 for CLK_DIV cycles → GAP.
  - GAP: `ssel_o`=1, `ready_o`=0 for SSEL_GAP cycles → IDLE.
- Data:
  - The MOSI shift register shifts left.
  - `mosi_o` changes only on shift edges (CPHA=1) or on trailing edges/SETUP (CPHA=0).
  - MISO is sampled on sample edges into a second shift register, LSB in.
- Back-to-back: `ready_o` is also 1 in the cycle edge 16 is issued when `last`=0. A transfer in that cycle skips WAIT, giving a continuous SCK with no gap.
- `busy_o` = state ≠ IDLE.

## Timing
- Reset values (asserted and in the cycle after release):
  - `sck_o`=CPOL, `ssel_o`=1, `mosi_o`=0.
  - `rx_data_or`=0, `rx_valid_o`=0, `busy_o`=0.
  - `ready_o`=0 while `reset_i`=1; `ready_o`=1 in the first cycle after release.
- Transfer in cycle T from IDLE:
  - `ssel_o`=0 and `mosi_o`=bit7 at T+1.
  - SCK edge k (k=1..16) appears on `sck_o` at T+1+k·CLK_DIV.
- `rx_valid_o` pulses one cycle after edge 16, i.e. at T+2+16·CLK_DIV, for both CPHA values.
- Last byte: `ssel_o` rises at T+1+17·CLK_DIV. `ready_o` returns to 1 SSEL_GAP cycles later.
- Boundary conditions:
  - `reset_i` in any state aborts: outputs go to reset values next cycle and no `rx_valid_o` is emitted for the partial byte.
  - `valid_i` dropping in WAIT is legal; SSEL stays low indefinitely.
  - `valid_i` high in GAP is not accepted.

## Configuration
- `SPI_TX_MISO_CAPTURE_EN`:
  - Defined: MISO sample register, `rx_data_or` and `rx_valid_o` are implemented as above.
  - Undefined: no MISO logic; `rx_data_or` is tied to 0, `rx_valid_o` is tied to 0, and `miso_i` is unused.

## Structure
- Package `spi_pkg`:
  - State encoding constants: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP.
  - `SPI_BITS`=8.
  - Edge-count width constant (5 bits, for 16 edges).
- Sub-module `spi_clk_div`: CLK_DIV counter emitting a one-cycle half-period tick; enabled in SETUP, SHIFT and HOLD, and cleared on entry to each.
- Top level holds the FSM, shift registers and handshake.

## Test plan
- CPOL=0, CPHA=0, CLK_DIV=4: send 0xA5 with `last`=1.
  - Required: SSEL low for 17·4 cycles.
  - Required: MOSI 1,0,1,0,0,1,0,1 stable at each rising edge.
  - Required: MISO loopback gives `rx_data_or`=0xA5.
- CPOL=1, CPHA=1: send 0x3C.
  - Required: SCK idles high.
  - Required: MOSI changes on falling edges.
  - Required: MISO tied 1 gives `rx_data_or`=0xFF.
- Three-byte frame 0x01, 0x02, 0x03 with `valid_i` always high.
  - Required: 48 continuous SCK edges.
  - Required: SSEL low throughout; three `rx_valid_o` pulses.
- `valid_i` withheld 20 cycles between bytes.
  - Required: SCK idle and SSEL low in WAIT.
  - Required: second byte's edge 1 at CLK_DIV+1 cycles after the transfer.
- `reset_i` asserted at edge 7.
  - Required: next cycle SSEL=1, SCK=CPOL, `rx_valid_o` never pulses.
  - Required: `ready_o`=1 the cycle after release.
- Build without `SPI_TX_MISO_CAPTURE_EN`.
  - Required: `rx_valid_o` stays 0 for a full frame.
  - Required: MOSI waveform identical to the first scenario.
